// File: rtl/calc_arb_cu_pkg.sv
// Shared definitions for the calculator control unit: state codes, control-word
// constants and ALU opcodes.
package calc_arb_cu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_LOADA = 3'b001;
  localparam logic [2:0] ST_LOADB = 3'b010;
  localparam logic [2:0] ST_EXEC  = 3'b011;
  localparam logic [2:0] ST_DISP  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOADA = ST_LOADA,
    S_LOADB = ST_LOADB,
    S_EXEC  = ST_EXEC,
    S_DISP  = ST_DISP
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // {Sel1,WA,WE,RAA,REA,RAB,REB,C,Sel2,done}; C sits at [3:2], done at [0].
  localparam int CW_W = 15;
  localparam logic [CW_W-1:0] CW_IDLE  = {2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, ALU_ADD, 1'b0, 1'b0};
  localparam logic [CW_W-1:0] CW_LOADA = {2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, ALU_ADD, 1'b0, 1'b0};
  localparam logic [CW_W-1:0] CW_LOADB = {2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, ALU_ADD, 1'b0, 1'b0};
  localparam logic [CW_W-1:0] CW_EXEC  = {2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, ALU_ADD, 1'b0, 1'b0};
  localparam logic [CW_W-1:0] CW_DISP  = {2'b01, 2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1, ALU_AND, 1'b1, 1'b1};

  function automatic logic [CW_W-1:0] cw_of(state_t st, logic [1:0] opl);
    case (st)
      S_LOADA: return CW_LOADA;
      S_LOADB: return CW_LOADB;
      S_EXEC:  return CW_EXEC | {11'b0, opl, 2'b00};
      S_DISP:  return CW_DISP;
      default: return CW_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/calc_arb_cu_if.sv
// Requester-side bus of the calculator control unit: requests and opcodes in,
// grants, datapath control word and status out.
interface calc_arb_cu_if #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0]   Req;
  logic [2*N_REQ-1:0] Op;
  logic [N_REQ-1:0]   Gnt;
  logic [2:0]         Src;
  logic [1:0]         Sel1;
  logic [1:0]         WA;
  logic               WE;
  logic [1:0]         RAA;
  logic               REA;
  logic [1:0]         RAB;
  logic               REB;
  logic [1:0]         C;
  logic               Sel2;
  logic [N_REQ-1:0]   Done;
  logic               Busy;
  logic [2:0]         CS;
  logic [CNT_W-1:0]   OpCnt;

  modport master (
    output Req, Op,
    input  Gnt, Src, Sel1, WA, WE, RAA, REA, RAB, REB, C, Sel2, Done, Busy, CS, OpCnt
  );

  modport slave (
    input  Req, Op,
    output Gnt, Src, Sel1, WA, WE, RAA, REA, RAB, REB, C, Sel2, Done, Busy, CS, OpCnt
  );
endinterface

// File: rtl/calc_arb_cu_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// at N_REQ-1 back to 0.
module calc_arb_cu_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             valid
);

  logic [7:0]       req_ext;
  logic [2:0]       cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  assign req_ext = 8'(req);

  // Candidate gi is the requester gi places after ptr, modulo N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, ptr} + 4'(gi);
      assign cand_idx[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
      assign cand_hit[gi] = req_ext[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        winner = cand_idx[i];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_arb_cu.sv
// Control unit sharing one calculator datapath among N_REQ requesters; each
// granted operation walks LOADA, LOADB, EXEC, DISP and pulses Done to its owner.
module calc_arb_cu
  import calc_arb_cu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 8
) (
  input logic          CLK,
  input logic          RST_n,
  calc_arb_cu_if.slave bus
);

  state_t           state_reg, state_next;
  logic [2:0]       src_reg, src_next;
  logic [1:0]       opl_reg, opl_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic [CW_W-2:0]  cw_reg;
  logic             busy_reg, busy_next;
  logic [CW_W-1:0]  cw_full;
  logic [7:0]       one_hot;
  logic [15:0]      op_ext;
  logic [2:0]       arb_idx;
  logic             arb_valid;

  calc_arb_cu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.Req),
    .ptr    (ptr_reg),
    .winner (arb_idx),
    .valid  (arb_valid)
  );

  assign op_ext = 16'(bus.Op);

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    opl_next   = opl_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (arb_valid) begin
          state_next = S_LOADA;
          src_next   = arb_idx;
          opl_next   = op_ext[{arb_idx, 1'b0} +: 2];
        end
      end
      S_LOADA: state_next = S_LOADB;
      S_LOADB: state_next = S_EXEC;
      S_EXEC:  state_next = S_DISP;
      S_DISP: begin
        state_next = S_IDLE;
        cnt_next   = cnt_reg + CNT_W'(1);
        ptr_next   = (src_reg == 3'(N_REQ - 1)) ? 3'd0 : src_reg + 3'd1;
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    cw_full   = cw_of(state_next, opl_next);
    one_hot   = 8'b1 << src_next;
    busy_next = (state_next != S_IDLE);
    gnt_next  = busy_next ? one_hot[N_REQ-1:0] : '0;
    done_next = cw_full[0] ? one_hot[N_REQ-1:0] : '0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= S_IDLE;
      src_reg   <= '0;
      opl_reg   <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      busy_reg  <= 1'b0;
      cw_reg    <= CW_IDLE[CW_W-1:1];
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      opl_reg   <= opl_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      cw_reg    <= cw_full[CW_W-1:1];
    end
  end

  assign {bus.Sel1, bus.WA, bus.WE, bus.RAA, bus.REA, bus.RAB, bus.REB, bus.C, bus.Sel2} = cw_reg;
  assign bus.Gnt   = gnt_reg;
  assign bus.Done  = done_reg;
  assign bus.Busy  = busy_reg;
  assign bus.Src   = src_reg;
  assign bus.CS    = state_reg;
  assign bus.OpCnt = cnt_reg;

endmodule

// File: tb/tb_calc_arb_cu.sv
// Bench for calc_arb_cu: cycle reference model plus a transaction scoreboard
// that pairs each grant with the Done pulse it should produce.
module tb_calc_arb_cu;

  localparam int N  = 2;
  localparam int CW = 8;

  typedef struct {
    int         owner;
    logic [1:0] op;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  calc_arb_cu_if #(.N_REQ(N), .CNT_W(CW)) bus ();

  calc_arb_cu #(.N_REQ(N), .CNT_W(CW)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err = 0;
  int         ops_seen = 0;
  txn_t       sb_q[$];
  int         owner_log[$];
  logic [1:0] exec_c_seen = 2'b00;

  int         m_state = 0;
  int         m_src = 0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [1:0] m_opl = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] exp_cw(input int st, input logic [1:0] opl);
    logic [14:0] w;
    case (st)
      1: w = 15'b11_01_1_00_0_00_0_00_0_0;
      2: w = 15'b10_10_1_00_0_00_0_00_0_0;
      3: begin
        w = 15'b00_11_1_01_1_10_1_00_0_0;
        w[3:2] = opl;
      end
      4: w = 15'b01_00_0_11_1_11_1_10_1_1;
      default: w = 15'b01_00_0_00_0_00_0_00_0_0;
    endcase
    return w;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [1:0] op_of(input logic [2*N-1:0] ops, input int idx);
    logic [2*N-1:0] sh;
    sh = ops >> (2 * idx);
    return sh[1:0];
  endfunction

  // Reference model; a grant pushes the expected transaction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_src   <= 0;
      m_opl   <= 2'b00;
      m_ptr   <= 0;
      m_cnt   <= 0;
      sb_q.delete();
    end else begin
      case (m_state)
        0: if (bus.Req != '0) begin
          m_state <= 1;
          m_src   <= rr_pick(bus.Req, m_ptr);
          m_opl   <= op_of(bus.Op, rr_pick(bus.Req, m_ptr));
          sb_q.push_back('{owner: rr_pick(bus.Req, m_ptr), op: op_of(bus.Op, rr_pick(bus.Req, m_ptr))});
        end
        4: begin
          m_state <= 0;
          m_cnt   <= (m_cnt + 1) % (1 << CW);
          m_ptr   <= (m_src + 1) % N;
        end
        default: m_state <= m_state + 1;
      endcase
    end
  end

  // Per-cycle output check and scoreboard pop on Done.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("cs", 32'(bus.CS), m_state);
      check_eq("cw", 32'({bus.Sel1, bus.WA, bus.WE, bus.RAA, bus.REA, bus.RAB, bus.REB,
                          bus.C, bus.Sel2, |bus.Done}), 32'(exp_cw(m_state, m_opl)));
      check_eq("gnt", 32'(bus.Gnt), (m_state != 0) ? (1 << m_src) : 0);
      check_eq("done", 32'(bus.Done), (m_state == 4) ? (1 << m_src) : 0);
      check_eq("busy", 32'(bus.Busy), 32'(m_state != 0));
      check_eq("opcnt", 32'(bus.OpCnt), m_cnt);
      if (m_state != 0) check_eq("src", 32'(bus.Src), m_src);
      if (bus.CS == 3'b011) exec_c_seen <= bus.C;
      if (bus.Done != '0) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", sb_q.size(), 1);
        end else begin
          check_eq("sb_owner", 32'(bus.Src), sb_q[0].owner);
          check_eq("sb_op", 32'(exec_c_seen), 32'(sb_q[0].op));
          $display("txn %0d owner=%0d op=%b done=%b opcnt_before=%0d",
                   ops_seen, bus.Src, exec_c_seen, bus.Done, bus.OpCnt);
          void'(sb_q.pop_front());
        end
        owner_log.push_back(int'(bus.Src));
        ops_seen <= ops_seen + 1;
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.Req = '0;
    bus.Op  = '0;
    repeat (2) @(negedge clk);
    owner_log.delete();
    rst_n = 1'b1;
    #1;
    check_eq("rst_cs", 32'(bus.CS), 0);
    check_eq("rst_gnt", 32'(bus.Gnt), 0);
    check_eq("rst_opcnt", 32'(bus.OpCnt), 0);
  endtask

  task automatic wait_ops(input int n);
    int target;
    target = ops_seen + n;
    for (int i = 0; i < n * 6 + 20 && ops_seen < target; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("wait_ops", ops_seen, target);
  endtask

  task automatic wait_cs(input logic [2:0] code);
    for (int i = 0; i < 40 && bus.CS != code; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("wait_cs", 32'(bus.CS), 32'(code));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    bus.Req = '0;
    bus.Op  = '0;

    // Single requester, AND opcode.
    do_reset();
    bus.Op  = 4'b0010;
    bus.Req = 2'b01;
    wait_ops(1);
    bus.Req = 2'b00;
    idle_cycles(2);
    check_eq("t1_opcnt", 32'(bus.OpCnt), 1);
    check_eq("t1_owner", owner_log[0], 0);

    // Both requesting: strict alternation, C follows the owner's opcode.
    do_reset();
    bus.Op  = 4'b1100;
    bus.Req = 2'b11;
    wait_ops(4);
    bus.Req = 2'b00;
    idle_cycles(2);
    check_eq("t2_n", owner_log.size(), 4);
    for (int i = 0; i < 4 && i < owner_log.size(); i++)
      check_eq($sformatf("t2_owner%0d", i), owner_log[i], i % 2);

    // Opcode change after grant is ignored.
    do_reset();
    bus.Op  = 4'b0001;
    bus.Req = 2'b01;
    wait_cs(3'b010);
    bus.Op = 4'b0011;
    wait_ops(1);
    bus.Req = 2'b00;
    idle_cycles(2);
    check_eq("t3_exec_c", 32'(exec_c_seen), 32'(2'b01));

    // Asynchronous reset during the second operation's EXEC.
    do_reset();
    bus.Op  = 4'b1001;
    bus.Req = 2'b11;
    wait_ops(1);
    wait_cs(3'b011);
    check_eq("t4_src_pre", 32'(bus.Src), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t4_cs", 32'(bus.CS), 0);
    check_eq("t4_cw", 32'({bus.Sel1, bus.WA, bus.WE, bus.RAA, bus.REA, bus.RAB, bus.REB,
                           bus.C, bus.Sel2}), 32'(14'b01_00_0_00_0_00_0_00_0));
    check_eq("t4_gnt", 32'(bus.Gnt), 0);
    check_eq("t4_done", 32'(bus.Done), 0);
    check_eq("t4_busy", 32'(bus.Busy), 0);
    check_eq("t4_opcnt", 32'(bus.OpCnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ops(1);
    bus.Req = 2'b00;
    check_eq("t4_owner", owner_log[owner_log.size()-1], 0);
    idle_cycles(2);

    // Request dropped in LOADA still completes, then the unit idles.
    do_reset();
    bus.Op  = 4'b0011;
    bus.Req = 2'b01;
    wait_cs(3'b001);
    bus.Req = 2'b00;
    wait_ops(1);
    idle_cycles(3);
    check_eq("t5_cs", 32'(bus.CS), 0);
    check_eq("t5_busy", 32'(bus.Busy), 0);
    check_eq("t5_opcnt", 32'(bus.OpCnt), 1);

    // Counter wrap after 2^CNT_W operations.
    do_reset();
    bus.Op  = 4'b0101;
    bus.Req = 2'b01;
    wait_ops(255);
    idle_cycles(1);
    check_eq("t6_opcnt255", 32'(bus.OpCnt), 255);
    wait_ops(1);
    bus.Req = 2'b00;
    idle_cycles(1);
    check_eq("t6_opcnt_wrap", 32'(bus.OpCnt), 0);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
